// File: rtl/hid_keycode_packer_if.sv
// Byte-stream input and packed keycode output bundle for hid_keycode_packer.
// slave = packer side, master = report source / keycode consumer side.
interface hid_keycode_packer_if;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;

  logic [BYTE_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;
  logic [WORD_W-1:0] keycode_word;
  logic [BYTE_W-1:0] modifiers;
  logic              word_valid;
  logic              err_short;
  logic              err_long;
  logic              err_rollover;

  modport slave (
    input  s_data, s_valid, s_last,
    output s_ready, keycode_word, modifiers, word_valid,
           err_short, err_long, err_rollover
  );

  modport master (
    output s_data, s_valid, s_last,
    input  s_ready, keycode_word, modifiers, word_valid,
           err_short, err_long, err_rollover
  );
endinterface

// File: rtl/hid_keycode_packer.sv
// Packs HID boot-keyboard report bytes into an atomic 32-bit keycode word.
// Optional stale-report clear: define HID_KEYCODE_PACKER_TIMEOUT_EN.
module hid_keycode_packer #(
  parameter int unsigned REPORT_BYTES   = 8,
  parameter int unsigned SLOTS          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                  Clk,
  input  logic                  Reset,
  hid_keycode_packer_if.slave   bus
);

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned SLOT_BITS = SLOTS * 8;
  localparam int unsigned IDX_W     = $clog2(REPORT_BYTES);
  localparam int unsigned CNT_W     = $clog2(SLOTS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REPORT_BYTES - 1);
  localparam logic [IDX_W-1:0] KEY_IDX0 = IDX_W'(2);
  localparam logic [CNT_W-1:0] SLOTS_C  = CNT_W'(SLOTS);
  localparam logic [7:0]       ROLLOVER_CODE = 8'h01;

  generate
    if (REPORT_BYTES < 3 || SLOTS < 1 || SLOT_BITS > WORD_W || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("hid_keycode_packer: illegal parameter set");
    end
  endgenerate

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  state_t                 r_state, w_state_next;
  logic [IDX_W-1:0]       r_idx, w_idx_next;
  logic [7:0]             r_stage_mod, w_mod_next;
  logic [SLOTS-1:0][7:0]  r_slots, w_slots_next;
  logic [CNT_W-1:0]       r_cnt, w_cnt_next;
  logic                   r_roll, w_roll_next;

  logic                   w_xfer;
  logic                   w_commit, w_short, w_long, w_rollerr;
  logic                   w_tmo_fire;

  logic                   r_ready;
  logic [WORD_W-1:0]      r_keycode_word;
  logic [7:0]             r_modifiers;
  logic                   r_word_valid, r_err_short, r_err_long, r_err_rollover;

  assign w_xfer = bus.s_valid && r_ready;

  // State and staging registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= COLLECT;
      r_idx       <= '0;
      r_stage_mod <= '0;
      r_slots     <= '0;
      r_cnt       <= '0;
      r_roll      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_idx       <= w_idx_next;
      r_stage_mod <= w_mod_next;
      r_slots     <= w_slots_next;
      r_cnt       <= w_cnt_next;
      r_roll      <= w_roll_next;
    end
  end

  // Next state; the commit outcome is decided on the edge that accepts the last byte
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_mod_next   = r_stage_mod;
    w_slots_next = r_slots;
    w_cnt_next   = r_cnt;
    w_roll_next  = r_roll;
    w_commit     = 1'b0;
    w_short      = 1'b0;
    w_long       = 1'b0;
    w_rollerr    = 1'b0;

    unique case (r_state)
      COLLECT: begin
        if (w_xfer) begin
          if (r_idx == '0) begin
            w_mod_next = bus.s_data;
          end else if (r_idx >= KEY_IDX0 && bus.s_data != '0) begin
            if (bus.s_data == ROLLOVER_CODE) w_roll_next = 1'b1;
            if (r_cnt < SLOTS_C) begin
              for (int k = 0; k < SLOTS; k++) begin
                if (CNT_W'(k) == r_cnt) w_slots_next[k] = bus.s_data;
              end
              w_cnt_next = r_cnt + CNT_W'(1);
            end
          end

          if (bus.s_last) begin
            if (r_idx == LAST_IDX) begin
              w_state_next = COMMIT;
              w_rollerr    = w_roll_next;
              w_commit     = !w_roll_next;
            end else begin
              w_short      = 1'b1;
              w_idx_next   = '0;
              w_mod_next   = '0;
              w_slots_next = '0;
              w_cnt_next   = '0;
              w_roll_next  = 1'b0;
            end
          end else if (r_idx == LAST_IDX) begin
            w_state_next = DRAIN;
          end else begin
            w_idx_next = r_idx + IDX_W'(1);
          end
        end
      end

      DRAIN: begin
        if (w_xfer && bus.s_last) begin
          w_long       = 1'b1;
          w_state_next = COLLECT;
          w_idx_next   = '0;
          w_mod_next   = '0;
          w_slots_next = '0;
          w_cnt_next   = '0;
          w_roll_next  = 1'b0;
        end
      end

      COMMIT: begin
        w_state_next = COLLECT;
        w_idx_next   = '0;
        w_mod_next   = '0;
        w_slots_next = '0;
        w_cnt_next   = '0;
        w_roll_next  = 1'b0;
      end

      default: begin
        w_state_next = COLLECT;
      end
    endcase
  end

`ifdef HID_KEYCODE_PACKER_TIMEOUT_EN
  localparam int unsigned       TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0]  TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] r_tmo;
  logic             w_load_evt;

  assign w_load_evt = w_commit | w_short | w_long | w_rollerr;

  // Stale-report counter; saturates so the clear fires once per idle stretch
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_tmo <= '0;
    end else if (w_load_evt) begin
      r_tmo <= '0;
    end else if (r_tmo != TMO_MAX) begin
      r_tmo <= r_tmo + TMO_W'(1);
    end
  end

  assign w_tmo_fire = !w_load_evt && (r_tmo == TMO_MAX - TMO_W'(1)) &&
                      (r_keycode_word != '0 || r_modifiers != '0);
`else
  assign w_tmo_fire = 1'b0;
`endif

  // Registered outputs
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_ready        <= 1'b1;
      r_keycode_word <= '0;
      r_modifiers    <= '0;
      r_word_valid   <= 1'b0;
      r_err_short    <= 1'b0;
      r_err_long     <= 1'b0;
      r_err_rollover <= 1'b0;
    end else begin
      r_ready        <= (w_state_next != COMMIT);
      r_word_valid   <= w_commit | w_tmo_fire;
      r_err_short    <= w_short;
      r_err_long     <= w_long;
      r_err_rollover <= w_rollerr;
      if (w_commit) begin
        r_keycode_word <= WORD_W'(w_slots_next);
        r_modifiers    <= w_mod_next;
      end else if (w_tmo_fire) begin
        r_keycode_word <= '0;
        r_modifiers    <= '0;
      end
    end
  end

  assign bus.s_ready      = r_ready;
  assign bus.keycode_word = r_keycode_word;
  assign bus.modifiers    = r_modifiers;
  assign bus.word_valid   = r_word_valid;
  assign bus.err_short    = r_err_short;
  assign bus.err_long     = r_err_long;
  assign bus.err_rollover = r_err_rollover;

endmodule

// File: tb/tb_hid_keycode_packer.sv
// Scoreboard bench for hid_keycode_packer: each report pushes its expected pulse/word,
// a negedge monitor pops and compares whenever the DUT pulses.
module tb_hid_keycode_packer;

  localparam int unsigned RB    = 8;
  localparam int unsigned SLOTS = 4;
  localparam int unsigned TMO   = 100;

  localparam logic [3:0] K_WORD  = 4'b1000;
  localparam logic [3:0] K_SHORT = 4'b0100;
  localparam logic [3:0] K_LONG  = 4'b0010;
  localparam logic [3:0] K_ROLL  = 4'b0001;

  typedef struct {
    logic [3:0]  kind;
    logic [31:0] word;
    logic [7:0]  mod;
  } exp_t;

  logic Clk;
  logic Reset;
  hid_keycode_packer_if bus();

  hid_keycode_packer #(
    .REPORT_BYTES  (RB),
    .SLOTS         (SLOTS),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int          n_checks;
  int          n_errors;
  exp_t        sb[$];
  logic [31:0] m_word;
  logic [7:0]  m_mod;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] pulses();
    return {bus.word_valid, bus.err_short, bus.err_long, bus.err_rollover};
  endfunction

  // Scoreboard monitor
  always @(negedge Clk) begin
    logic [3:0] p;
    exp_t e;
    p = pulses();
    if (!Reset && p != 4'b0000) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'(p), 32'h0);
      end else begin
        e = sb.pop_front();
        check("pulse_kind", 32'(p), 32'(e.kind));
        check("keycode_word", bus.keycode_word, e.word);
        check("modifiers", 32'(bus.modifiers), 32'(e.mod));
      end
    end
  end

  // Independent report model: pushes the expected outcome
  task automatic predict(input logic [7:0] b[$]);
    exp_t        e;
    logic        roll;
    logic [31:0] w;
    int          k;
    e.word = m_word;
    e.mod  = m_mod;
    if (b.size() < RB) begin
      e.kind = K_SHORT;
    end else if (b.size() > RB) begin
      e.kind = K_LONG;
    end else begin
      roll = 1'b0;
      w    = '0;
      k    = 0;
      for (int i = 2; i < b.size(); i++) begin
        if (b[i] != 8'h00) begin
          if (b[i] == 8'h01) roll = 1'b1;
          if (k < SLOTS) begin
            w[8*k +: 8] = b[i];
            k++;
          end
        end
      end
      if (roll) begin
        e.kind = K_ROLL;
      end else begin
        e.kind = K_WORD;
        e.word = w;
        e.mod  = b[0];
        m_word = w;
        m_mod  = b[0];
      end
    end
    sb.push_back(e);
  endtask

  // Drives bytes honoring s_ready; with do_last, checks the pulse one cycle after the last byte
  task automatic send(input logic [7:0] b[$], input bit do_last);
    bit rdy;
    bit ok;
    if (do_last) predict(b);
    for (int i = 0; i < b.size(); i++) begin
      ok = 1'b0;
      @(negedge Clk);
      bus.s_valid = 1'b1;
      bus.s_data  = b[i];
      bus.s_last  = do_last && (i == b.size() - 1);
      for (int t = 0; t < 20 && !ok; t++) begin
        if (t != 0) @(negedge Clk);
        rdy = bus.s_ready;
        @(posedge Clk);
        ok = rdy;
      end
      if (!ok) check("ready_timeout", 32'h0, 32'h1);
    end
    @(negedge Clk);
    if (do_last) check("latency", 32'(|pulses()), 32'h1);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_data  = 8'h00;
  endtask

  task automatic rand_report();
    logic [7:0] b[$];
    int v;
    b.push_back(8'($urandom_range(0, 255)));
    b.push_back(8'($urandom_range(0, 255)));
    for (int i = 2; i < RB; i++) begin
      v = $urandom_range(0, 15);
      if (v < 6)       b.push_back(8'h00);
      else if (v == 15) b.push_back(($urandom_range(0, 3) == 0) ? 8'h01 : 8'h3A);
      else             b.push_back(8'(8'h04 + v));
    end
    send(b, 1'b1);
  endtask

  initial begin
    logic [7:0] b[$];
    n_checks    = 0;
    n_errors    = 0;
    m_word      = '0;
    m_mod       = '0;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_data  = 8'h00;
    Reset       = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_word", bus.keycode_word, 32'h0);
    check("rst_mod", 32'(bus.modifiers), 32'h0);
    check("rst_ready", 32'(bus.s_ready), 32'h1);
    check("rst_pulses", 32'(pulses()), 32'h0);
    @(negedge Clk);
    Reset = 1'b0;

    b = '{8'h00, 8'h00, 8'h04, 8'h1A, 8'h00, 8'h00, 8'h00, 8'h00};
    send(b, 1'b1);
    b = '{8'h02, 8'h00, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    send(b, 1'b1);
    b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send(b, 1'b1);
    b = '{8'h00, 8'h00, 8'h15, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send(b, 1'b1);
    b = '{8'h00, 8'h00, 8'h04};
    send(b, 1'b1);
    b = '{8'h20, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h1E};
    send(b, 1'b1);
    b = '{8'h00, 8'h00, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B};
    send(b, 1'b1);
    b = '{8'h00, 8'h00, 8'h2C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send(b, 1'b1);
    b = '{8'h00, 8'h00, 8'h16, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send(b, 1'b1);
    b = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    send(b, 1'b1);
    b = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    send(b, 1'b1);
    b = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send(b, 1'b1);

    for (int r = 0; r < 20; r++) rand_report();

    b = '{8'h04, 8'h00, 8'h1D, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send(b, 1'b1);
    b = '{8'h00, 8'h00, 8'h05, 8'h06};
    send(b, 1'b0);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h07;
    #3;
    Reset = 1'b1;
    #1;
    check("async_rst_word", bus.keycode_word, 32'h0);
    check("async_rst_mod", 32'(bus.modifiers), 32'h0);
    check("async_rst_ready", 32'(bus.s_ready), 32'h1);
    bus.s_valid = 1'b0;
    m_word = '0;
    m_mod  = '0;
    @(negedge Clk);
    Reset = 1'b0;
    b = '{8'h00, 8'h00, 8'h2C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send(b, 1'b1);

`ifdef HID_KEYCODE_PACKER_TIMEOUT_EN
    b = '{8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send(b, 1'b1);
    begin
      exp_t e;
      e.kind = K_WORD;
      e.word = 32'h0;
      e.mod  = 8'h0;
      sb.push_back(e);
    end
    m_word = '0;
    m_mod  = '0;
    repeat (3 * TMO) @(negedge Clk);
    check("tmo_word", bus.keycode_word, 32'h0);
`else
    repeat (50) @(negedge Clk);
    check("hold_word", bus.keycode_word, m_word);
    check("hold_mod", 32'(bus.modifiers), 32'(m_mod));
`endif

    repeat (3) @(negedge Clk);
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/hid_keycode_packer.md
Name: hid_keycode_packer

Overview:
- Writer side of the keycode word consumed by the game logic: turns the raw USB HID boot-keyboard report byte stream into packed 32-bit keycode words.
- Fed by the USB host firmware bridge as a byte stream.
- Produces the 32-bit word the player/menu logic reads, plus the modifier byte and status pulses.
- Each word update is atomic per complete, well-formed report.

Parameters:
- REPORT_BYTES, 8: bytes per report. Byte 0 is the modifier, byte 1 is reserved, bytes 2..REPORT_BYTES-1 are keycodes. Minimum 3.
- SLOTS, 4: keycode slots packed into keycode_word, 8 bits each. Must satisfy SLOTS*8 <= 32.
- TIMEOUT_CYCLES, 50_000_000: stale-report timeout in Clk cycles. Used only with the optional feature.

Ports:
- Clk, in, 1: system clock.
- Reset, in, 1: asynchronous, active-high reset.
- s_data, in, 8: report byte.
- s_valid, in, 1: byte valid.
- s_last, in, 1: final byte of the report, qualified by s_valid.
- s_ready, out, 1: packer accepts the byte this cycle.
- keycode_word, out, 32: packed keycodes. Slot k occupies bits [8k+7:8k]; unused slots and bits are 0.
- modifiers, out, 8: modifier byte of the last committed report.
- word_valid, out, 1: one-cycle pulse when keycode_word/modifiers update.
- err_short, out, 1: one-cycle pulse when a report is discarded as too short.
- err_long, out, 1: one-cycle pulse when a report is discarded as too long.
- err_rollover, out, 1: one-cycle pulse when a report is discarded for phantom-key rollover.

Behaviour:
- Reset values: keycode_word=0, modifiers=0, all pulses 0, s_ready=1, state COLLECT, byte counter 0, staging registers 0.
- A transfer occurs when s_valid && s_ready.
- State COLLECT:
  - Counter idx (0..REPORT_BYTES-1) counts accepted bytes.
  - idx 0 goes to staged modifier. idx 1 is ignored.
  - idx >= 2 with a nonzero byte goes to the next free staging slot, in arrival order.
  - Zero bytes are skipped. Nonzero bytes beyond SLOTS are dropped silently.
  - Byte value 0x01 sets a sticky rollover flag.
  - s_last on idx == REPORT_BYTES-1 -> COMMIT.
  - s_last on idx < REPORT_BYTES-1 -> pulse err_short the next cycle, clear staging, go to COLLECT with idx=0. Outputs are unchanged.
  - idx == REPORT_BYTES-1 accepted without s_last -> DRAIN.
- State DRAIN:
  - Accept and discard bytes until s_last.
  - On s_last, pulse err_long the next cycle, clear staging, return to COLLECT.
- State COMMIT (exactly one cycle, s_ready=0):
  - If the rollover flag is set: pulse err_rollover; keycode_word and modifiers hold their previous values.
  - Otherwise: load keycode_word and modifiers from staging and pulse word_valid.
  - Either way, clear staging and idx, then return to COLLECT.
- Latency: word_valid is asserted 1 cycle after the last byte is accepted. Back-to-back reports lose one cycle per report to COMMIT.
- Duplicate reports still pulse word_valid (no change filtering).
- s_ready is 1 in COLLECT and DRAIN and 0 only in COMMIT. Bytes presented during COMMIT are held by the source (valid/ready rule); the source must not drop s_valid.
- At most one pulse output is high in any cycle.
- Reset asserted mid-report aborts the report; outputs return to reset values immediately.

Optional Feature:
- Macro: HID_KEYCODE_PACKER_TIMEOUT_EN.
- When defined:
  - A counter reloads to 0 on each commit and on each discarded report, and increments otherwise, saturating at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES with keycode_word != 0 or modifiers != 0: clear both to 0 and pulse word_valid once. This prevents stuck keys if the USB host stalls.
  - The pulse must not coincide with a COMMIT pulse; COMMIT wins and reloads the counter.
- When undefined: no counter; outputs hold indefinitely.

Test Plan:
- Report 00,00,04,1A,00,00,00,00 (last on byte 8) -> 1 cycle later word_valid=1, keycode_word=0x00001A04, modifiers=0x00.
- Report 02,00,04,05,06,07,08,09 -> keycode_word=0x07060504 (slots beyond 4 dropped), modifiers=0x02; then 00×8 -> keycode_word=0, word_valid pulses.
- Short report 00,00,04 with last on byte 3 -> err_short pulse, keycode_word unchanged; the following valid report commits normally.
- 10-byte report with last on byte 10 -> err_long after byte 10 only, no word_valid; then 00,00,2C,0,0,0,0,0 -> keycode_word=0x0000002C.
- Rollover: commit 0x16, then report 00,00,01,01,01,01,01,01 -> err_rollover, keycode_word stays 0x00000016. Also assert Reset mid-report -> all outputs 0 asynchronously and the next report starts at idx 0.
- With HID_KEYCODE_PACKER_TIMEOUT_EN and TIMEOUT_CYCLES=100: commit 0x04, idle 100 cycles -> keycode_word=0 with one word_valid pulse; no further pulses while idle.
